psum_writeback: RTL and testbench

- Drains completed output rows from the psum buffer and pushes them into the output (DRAM-write) FIFO. Each written word carries a sequential DRAM write address.
- Sits on the consumer side of the psum buffer. The upstream controller fills the buffer (psumEn/first/last); this block reads it back after each row completes.
- Frees the buffer row and reports frame completion to the top level.

---
 rtl/psum_writeback.sv | 129 ++++++++++++
 tb/tb_psum_writeback.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/psum_writeback.sv
// Drains completed psum rows into the DRAM-write FIFO with saturation and sequential addressing.
// Build option: define WB_RELU_EN to clamp negative psums to zero before saturation.
module psum_writeback #(
  parameter int PSUM_W   = 24,
  parameter int DATA_W   = 16,
  parameter int ROW_LEN  = 28,
  parameter int OUT_ROWS = 28,
  parameter int DRAM_AW  = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rowDone,
  input  logic signed [PSUM_W-1:0]  psumRdata,
  output logic                      psumRen,
  output logic [5:0]                psumRaddr,
  input  logic                      fifoAfull,
  output logic                      fifoWen,
  output logic [DATA_W+DRAM_AW-1:0] fifoWdata,
  output logic                      rowFreed,
  output logic                      frameDone,
  output logic                      busy,
  output logic                      overflow
);

  localparam int RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam logic [5:0]    LAST_RD  = 6'(ROW_LEN - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(OUT_ROWS - 1);
  localparam logic signed [PSUM_W-1:0] SAT_MAX = PSUM_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [PSUM_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t               state_q, state_d;
  logic [1:0]           pend_q, pend_d;
  logic [5:0]           rd_cnt_q, rd_cnt_d;
  logic [RW-1:0]        row_cnt_q, row_cnt_d;
  logic [DRAM_AW-1:0]   waddr_q, waddr_d;
  logic                 rv_q, rv_d;
  logic                 overflow_q, overflow_d;

  logic                 start;
  logic                 rd_en;
  logic signed [PSUM_W-1:0] conv_in;
  logic [DATA_W-1:0]    sat_data;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    rd_cnt_d   = rd_cnt_q;
    row_cnt_d  = row_cnt_q;
    waddr_d    = waddr_q;
    overflow_d = overflow_q;
    rd_en      = 1'b0;
    start      = (state_q == IDLE) && (pend_q != 2'd0);

    case (state_q)
      IDLE: begin
        rd_cnt_d = '0;
        if (start) state_d = DRAIN;
      end
      DRAIN: begin
        if (!fifoAfull) begin
          rd_en    = 1'b1;
          rd_cnt_d = rd_cnt_q + 6'd1;
          if (rd_cnt_q == LAST_RD) state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d   = IDLE;
        row_cnt_d = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A rowDone coinciding with a row start cancels out; a third pending row is dropped.
    case ({rowDone, start})
      2'b10: begin
        if (pend_q == 2'd2) overflow_d = 1'b1;
        else                pend_d     = pend_q + 2'd1;
      end
      2'b01:   pend_d = pend_q - 2'd1;
      default: pend_d = pend_q;
    endcase

    rv_d = rd_en;
    if (rv_q) waddr_d = waddr_q + 1'b1;
  end

  always_comb begin
    conv_in = psumRdata;
`ifdef WB_RELU_EN
    if (conv_in[PSUM_W-1]) conv_in = '0;
`endif
    if (conv_in > SAT_MAX)      sat_data = SAT_MAX[DATA_W-1:0];
    else if (conv_in < SAT_MIN) sat_data = SAT_MIN[DATA_W-1:0];
    else                        sat_data = conv_in[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      rd_cnt_q   <= '0;
      row_cnt_q  <= '0;
      waddr_q    <= '0;
      rv_q       <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      rd_cnt_q   <= rd_cnt_d;
      row_cnt_q  <= row_cnt_d;
      waddr_q    <= waddr_d;
      rv_q       <= rv_d;
      overflow_q <= overflow_d;
    end
  end

  // Read data lands one cycle after the read, so the write is formed from it directly.
  assign psumRen   = rd_en;
  assign psumRaddr = rd_cnt_q;
  assign rowFreed  = rd_en && (rd_cnt_q == LAST_RD);
  assign fifoWen   = rv_q;
  assign fifoWdata = rv_q ? {waddr_q, sat_data} : '0;
  assign frameDone = rv_q && (state_q == FLUSH) && (row_cnt_q == LAST_ROW);
  assign busy      = (state_q != IDLE);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_psum_writeback.sv
// Scoreboard bench for psum_writeback (ROW_LEN=4, OUT_ROWS=2, DRAM_AW=3).
module tb_psum_writeback;
  localparam int PSUM_W = 24, DATA_W = 16, ROW_LEN = 4, OUT_ROWS = 2, DRAM_AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rowDone = 1'b0;
  logic signed [PSUM_W-1:0] psumRdata = '0;
  logic psumRen;
  logic [5:0] psumRaddr;
  logic fifoAfull = 1'b0;
  logic fifoWen;
  logic [DATA_W+DRAM_AW-1:0] fifoWdata;
  logic rowFreed, frameDone, busy, overflow;

  psum_writeback #(.PSUM_W(PSUM_W), .DATA_W(DATA_W), .ROW_LEN(ROW_LEN),
                   .OUT_ROWS(OUT_ROWS), .DRAM_AW(DRAM_AW)) dut (
    .clk(clk), .rst(rst), .rowDone(rowDone), .psumRdata(psumRdata),
    .psumRen(psumRen), .psumRaddr(psumRaddr), .fifoAfull(fifoAfull),
    .fifoWen(fifoWen), .fifoWdata(fifoWdata), .rowFreed(rowFreed),
    .frameDone(frameDone), .busy(busy), .overflow(overflow));

  always #5 clk = ~clk;

  logic signed [PSUM_W-1:0] mem [4];
  always @(posedge clk) psumRdata <= psumRen ? mem[psumRaddr[1:0]] : '0;

  int checks = 0;
  int failures = 0;
  logic [19:0] exp_q [$];
  logic [2:0] exp_waddr = '0;
  int exp_row = 0;
  int exp_rd = 0;

`ifdef WB_RELU_EN
  localparam logic [63:0] EXP_A = 64'h0000_7FFF_0000_0005;
  localparam logic [63:0] EXP_B = 64'h0000_7FFF_0000_0064;
  localparam logic [63:0] EXP_C = 64'h0000_0000_7FFF_0000;
`else
  localparam logic [63:0] EXP_A = 64'h8000_7FFF_FFFD_0005;
  localparam logic [63:0] EXP_B = 64'h8000_7FFF_FF9C_0064;
  localparam logic [63:0] EXP_C = 64'h8000_0000_7FFF_FFFF;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Expected entry: {frameDone, address, data}
  task automatic push_row(input logic [63:0] ev, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(exp_row == OUT_ROWS - 1) && (i == ROW_LEN - 1), exp_waddr, ev[16*i +: 16]});
      exp_waddr = exp_waddr + 3'd1;
    end
    if (n == ROW_LEN) exp_row = (exp_row + 1) % OUT_ROWS;
  endtask

  task automatic set_mem(input int a, input int b, input int c, input int d);
    mem[0] = PSUM_W'(a); mem[1] = PSUM_W'(b); mem[2] = PSUM_W'(c); mem[3] = PSUM_W'(d);
  endtask

  task automatic pulse;
    @(posedge clk); #1 rowDone = 1'b1;
    @(posedge clk); #1 rowDone = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0 || fifoWen) && n < 300);
    chk({name, "_idle_timeout"}, n < 300, 1);
  endtask

  // Monitor: checks every read address and every FIFO write against the model.
  always @(negedge clk) begin
    if (rst) exp_rd = 0;
    else begin
      if (psumRen) begin
        chk("psumRaddr", psumRaddr, exp_rd);
        chk("rowFreed", rowFreed, exp_rd == ROW_LEN - 1);
        exp_rd = (exp_rd + 1) % ROW_LEN;
      end else if (rowFreed) chk("rowFreed_without_read", rowFreed, 0);
      if (fifoWen) begin
        if (exp_q.size() == 0) chk("unexpected_write", fifoWen, 0);
        else chk("write_frame_addr_data", {frameDone, fifoWdata}, exp_q.pop_front());
      end else if (frameDone) chk("frameDone_without_write", frameDone, 0);
    end
  end

  initial begin
    set_mem(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_psumRen", psumRen, 0);
    chk("reset_fifoWen", fifoWen, 0);
    chk("reset_fifoWdata", fifoWdata, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_raddr", psumRaddr, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Row A: saturation of both polarities
    set_mem(5, -3, 70000, -70000);
    push_row(EXP_A, 4);
    pulse();
    wait_idle("rowA");

    // Row B: back-pressure for 3 cycles after the 2nd read
    set_mem(100, -100, 32767, -32769);
    push_row(EXP_B, 4);
    pulse();
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!(psumRen && psumRaddr == 6'd1) && n < 50);
      chk("rowB_read1_seen", n < 50, 1);
      @(posedge clk); #1 fifoAfull = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("afull_no_read", psumRen, 0);
      end
      @(posedge clk); #1 fifoAfull = 1'b0;
    end
    wait_idle("rowB");

    // Rows C,D,E plus a lost fourth row
    set_mem(-1, 40000, 0, -32768);
    push_row(EXP_C, 4);
    pulse();
    push_row(EXP_C, 4);
    pulse();
    push_row(EXP_C, 4);
    pulse();
    pulse();
    wait_idle("overflow_rows");
    chk("overflow_set", overflow, 1);
    repeat (5) @(negedge clk);
    chk("no_extra_row_busy", busy, 0);

    // Rows G,H: second rowDone lands on the IDLE->DRAIN cycle
    push_row(EXP_C, 4);
    push_row(EXP_C, 4);
    @(posedge clk); #1 rowDone = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rowDone = 1'b0;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!rowFreed && n < 50);
      chk("rowG_freed_seen", n < 50, 1);
      n = 0;
      do begin @(negedge clk); n++; end while (!psumRen && n < 50);
      chk("rowH_start_gap", n, 3);
    end
    wait_idle("rowsGH");
    chk("overflow_sticky", overflow, 1);

    // Row I: reset during drain, only the first two writes escape
    set_mem(11, 22, 33, 44);
    push_row(64'h002C_0021_0016_000B, 2);
    pulse();
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!(psumRen && psumRaddr == 6'd2) && n < 50);
      chk("rowI_read2_seen", n < 50, 1);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_psumRen", psumRen, 0);
    chk("rst_fifoWen", fifoWen, 0);
    chk("rst_fifoWdata", fifoWdata, 0);
    chk("rst_rowFreed", rowFreed, 0);
    chk("rst_frameDone", frameDone, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_raddr", psumRaddr, 0);
    chk("rst_queue_drained", exp_q.size(), 0);
    exp_q.delete();
    exp_waddr = '0;
    exp_row = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_fifoWen", fifoWen, 0);

    // Row J: restarts at read 0 and write address 0
    set_mem(5, -3, 70000, -70000);
    push_row(EXP_A, 4);
    pulse();
    wait_idle("rowJ");
    chk("final_overflow", overflow, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
